// File: rtl/game_pkg.sv
// Shared state codes, result codes and game constants for the tile game controller.
package game_pkg;

   typedef enum logic [2:0] {
      S_INIT    = 3'b000,
      S_RASP    = 3'b001,
      S_BAWP    = 3'b010,
      S_P1_TURN = 3'b011,
      S_P2_TURN = 3'b100,
      S_MATCH   = 3'b101,
      S_GAME    = 3'b110
   } state_t;

   localparam logic [1:0] RES_NONE = 2'b00;
   localparam logic [1:0] RES_DRAW = 2'b01;
   localparam logic [1:0] RES_P1   = 2'b10;
   localparam logic [1:0] RES_P2   = 2'b11;

   localparam int unsigned CNT_W      = 4;
   localparam int unsigned TILE_N     = 9;
   localparam int unsigned MAX_ROUND  = 9;
   localparam int unsigned WIN_TARGET = 5;
   localparam int unsigned TILE_MAX   = 8;
   localparam int unsigned INIT_BLACK = 5;
   localparam int unsigned INIT_WHITE = 4;

endpackage

// File: rtl/game_controller_hold_timer.sv
// Hold counter for the timed display states; done_c flags the last held cycle.
module hold_timer #(
   parameter int unsigned HOLD_CYCLES = 100_000_000,
   parameter int unsigned HOLD_W      = 27
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic count,
   output logic done_c
);

   logic [HOLD_W-1:0] cnt;

   // Count while a timed state is active; clear restarts from zero on state entry.
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         cnt <= '0;
      end else if (count) begin
         cnt <= cnt + HOLD_W'(1);
      end
   end

   assign done_c = count && (cnt == HOLD_W'(HOLD_CYCLES - 1));

endmodule

// File: rtl/game_controller.sv
// Game sequencing FSM with round/score bookkeeping and per-player tile inventories.
module game_controller
   import game_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES = 100_000_000,
   parameter int unsigned HOLD_W      = 27
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             btn_start,
   input  logic             btn_submit,
   input  logic [3:0]       tile_sel,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] round,
   output logic [CNT_W-1:0] win,
   output logic [CNT_W-1:0] lose,
   output logic [CNT_W-1:0] p1_black,
   output logic [CNT_W-1:0] p1_white,
   output logic [CNT_W-1:0] p2_black,
   output logic [CNT_W-1:0] p2_white,
   output logic [1:0]       matchresult,
   output logic [1:0]       gameresult
);

   state_t            state_q;
   logic [TILE_N-1:0] p1_mask, p2_mask;
   logic [3:0]        p1_tile, p2_tile;
   logic              leader_p2;

   logic              timed_c, hold_clear_c, hold_done;
   logic              cur_p2, is_follower, submit_ok;
   logic [TILE_N-1:0] sel_bit, mask_cur;
   logic [3:0]        p1_val, p2_val;

   assign state = state_q;

   // Timer runs only in the held display states and restarts on every transition out.
   assign timed_c      = (state_q == S_RASP) || (state_q == S_BAWP) || (state_q == S_MATCH);
   assign hold_clear_c = !timed_c || hold_done;

   hold_timer #(
      .HOLD_CYCLES (HOLD_CYCLES),
      .HOLD_W      (HOLD_W)
   ) u_hold_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (hold_clear_c),
      .count  (timed_c),
      .done_c (hold_done)
   );

   // Submit qualification and the tile pair compared when the follower commits.
   assign cur_p2      = (state_q == S_P2_TURN);
   assign is_follower = (cur_p2 != leader_p2);
   assign sel_bit     = TILE_N'(1) << tile_sel;
   assign mask_cur    = cur_p2 ? p2_mask : p1_mask;
   assign submit_ok   = btn_submit && (tile_sel <= 4'(TILE_MAX)) && ((mask_cur & sel_bit) == '0);
   assign p1_val      = cur_p2 ? p1_tile : tile_sel;
   assign p2_val      = cur_p2 ? tile_sel : p2_tile;

   // Main sequencer: state register plus all bookkeeping registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_INIT;
         round       <= '0;
         win         <= '0;
         lose        <= '0;
         p1_black    <= CNT_W'(INIT_BLACK);
         p1_white    <= CNT_W'(INIT_WHITE);
         p2_black    <= CNT_W'(INIT_BLACK);
         p2_white    <= CNT_W'(INIT_WHITE);
         p1_mask     <= '0;
         p2_mask     <= '0;
         p1_tile     <= '0;
         p2_tile     <= '0;
         leader_p2   <= 1'b0;
         matchresult <= RES_NONE;
         gameresult  <= RES_NONE;
      end else begin
         case (state_q)
            S_INIT: begin
               if (btn_start) begin
                  state_q     <= S_RASP;
                  round       <= CNT_W'(1);
                  win         <= '0;
                  lose        <= '0;
                  p1_black    <= CNT_W'(INIT_BLACK);
                  p1_white    <= CNT_W'(INIT_WHITE);
                  p2_black    <= CNT_W'(INIT_BLACK);
                  p2_white    <= CNT_W'(INIT_WHITE);
                  p1_mask     <= '0;
                  p2_mask     <= '0;
                  leader_p2   <= 1'b0;
                  matchresult <= RES_NONE;
                  gameresult  <= RES_NONE;
               end
            end
            S_RASP: begin
               if (hold_done) state_q <= S_BAWP;
            end
            S_BAWP: begin
               if (hold_done) state_q <= leader_p2 ? S_P2_TURN : S_P1_TURN;
            end
            S_P1_TURN, S_P2_TURN: begin
               if (submit_ok) begin
                  if (cur_p2) begin
                     p2_tile <= tile_sel;
                     p2_mask <= p2_mask | sel_bit;
                     if (tile_sel[0]) p2_white <= p2_white - CNT_W'(1);
                     else             p2_black <= p2_black - CNT_W'(1);
                  end else begin
                     p1_tile <= tile_sel;
                     p1_mask <= p1_mask | sel_bit;
                     if (tile_sel[0]) p1_white <= p1_white - CNT_W'(1);
                     else             p1_black <= p1_black - CNT_W'(1);
                  end
                  if (!is_follower) begin
                     state_q <= cur_p2 ? S_P1_TURN : S_P2_TURN;
                  end else begin
                     state_q <= S_MATCH;
                     if (p1_val > p2_val) begin
                        matchresult <= RES_P1;
                        win         <= win + CNT_W'(1);
                        leader_p2   <= 1'b0;
                     end else if (p2_val > p1_val) begin
                        matchresult <= RES_P2;
                        lose        <= lose + CNT_W'(1);
                        leader_p2   <= 1'b1;
                     end else begin
                        matchresult <= RES_DRAW;
                     end
                  end
               end
            end
            S_MATCH: begin
               if (hold_done) begin
                  if ((round == CNT_W'(MAX_ROUND)) || (win == CNT_W'(WIN_TARGET)) ||
                      (lose == CNT_W'(WIN_TARGET))) begin
                     state_q    <= S_GAME;
                     gameresult <= (win > lose) ? RES_P1 : ((lose > win) ? RES_P2 : RES_DRAW);
                  end else begin
                     state_q     <= S_RASP;
                     round       <= round + CNT_W'(1);
                     matchresult <= RES_NONE;
                  end
               end
            end
            S_GAME: begin
               if (btn_start) state_q <= S_INIT;
            end
            default: state_q <= S_INIT;
         endcase
      end
   end

endmodule
